nonogram_solution_checker: RTL and testbench

Receives the 70-word constraint stream produced by the constraint generator (30 row words, then 40 column words) plus a player-drawn 30x40 grid, then re-scans every line and reports per-line and overall agreement with the stored constraints. It sits on the consumer side of the constraint stream, between the generator and the game/display logic that needs a "puzzle solved" indication.

---
 rtl/nonogram_solution_checker.sv | 191 +++++++++++++++++++
 tb/tb_nonogram_solution_checker.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonogram_solution_checker.sv
// Stores a 70-word nonogram constraint set and a 30x40 player grid, then
// re-scans every row and column one pixel per cycle and reports line and overall agreement.
module nonogram_solution_checker #(
  parameter int HEIGHT   = 30,
  parameter int WIDTH    = 40,
  parameter int FIELD_W  = 6,
  parameter int MAX_RUNS = 20
) (
  input  logic                          clk_in,
  input  logic                          reset_n_in,
  input  logic                          constraint_valid_in,
  input  logic [FIELD_W*MAX_RUNS-1:0]   constraints_in,
  input  logic                          constraint_clear_in,
  input  logic                          grid_valid_in,
  input  logic [WIDTH-1:0]              grid_row_in,
  input  logic                          check_start_in,
  output logic                          constraints_loaded_out,
  output logic                          busy_out,
  output logic                          done_out,
  output logic [HEIGHT-1:0]             row_ok_out,
  output logic [WIDTH-1:0]              col_ok_out,
  output logic                          solved_out
);

  localparam int LINES  = HEIGHT + WIDTH;
  localparam int WORD_W = FIELD_W * MAX_RUNS;
  localparam int LW     = $clog2(LINES);
  localparam int PW     = $clog2(WIDTH);
  localparam int RW     = $clog2(HEIGHT);
  localparam int KW     = $clog2(MAX_RUNS + 1);

  typedef enum logic [1:0] {IDLE, SCAN, FINISH, DONE} state_t;
  state_t state_reg, state_next;

  logic [WORD_W-1:0]  cons_mem [0:LINES-1];
  logic [WIDTH-1:0]   grid_mem [0:HEIGHT-1];

  logic [LW-1:0]      word_cnt_reg;
  logic               loaded_reg;
  logic [RW-1:0]      grid_ptr_reg;
  logic               col_phase_reg;
  logic [PW-1:0]      line_reg;
  logic [PW-1:0]      pos_reg;
  logic [FIELD_W-1:0] run_reg;
  logic [KW-1:0]      k_reg;
  logic               fail_reg;
  logic [HEIGHT-1:0]  row_ok_reg;
  logic [WIDTH-1:0]   col_ok_reg;
  logic               solved_reg;
  logic               done_reg;

  logic               idle;
  logic               clear_en, load_en, grid_en, start_en;
  logic [LW-1:0]      line_addr;
  logic [WORD_W-1:0]  cur_word;
  logic               pixel;
  logic               last_pix, last_line;
  logic               k_full, close_fail, run_open, line_fail;
  logic [KW-1:0]      k_inc, k_after;
  logic [FIELD_W-1:0] fields [0:MAX_RUNS];

  assign idle     = (state_reg == IDLE);
  assign clear_en = idle & constraint_clear_in;
  assign load_en  = idle & constraint_valid_in & ~constraint_clear_in & ~loaded_reg;
  assign grid_en  = idle & grid_valid_in;
  assign start_en = idle & check_start_in & loaded_reg & ~constraint_clear_in;

  // Column lines live after the row words in constraint storage.
  assign line_addr = col_phase_reg ? (LW'(line_reg) + LW'(HEIGHT)) : LW'(line_reg);
  assign cur_word  = cons_mem[line_addr];
  assign pixel     = col_phase_reg ? grid_mem[pos_reg[RW-1:0]][line_reg]
                                   : grid_mem[line_reg[RW-1:0]][pos_reg];

  genvar gi;
  generate
    for (gi = 0; gi < MAX_RUNS; gi++) begin : g_field
      assign fields[gi] = cur_word[gi*FIELD_W +: FIELD_W];
    end
  endgenerate
  // A saturated field index reads as an empty field, so "no more runs expected".
  assign fields[MAX_RUNS] = '0;

  assign k_full     = (k_reg == KW'(MAX_RUNS));
  assign close_fail = k_full | (run_reg != fields[k_reg]);
  assign k_inc      = k_full ? k_reg : (k_reg + KW'(1));
  assign run_open   = (run_reg != '0);
  assign k_after    = run_open ? k_inc : k_reg;
  assign line_fail  = fail_reg | (run_open & close_fail) | (fields[k_after] != '0);
  assign last_pix   = col_phase_reg ? (pos_reg == PW'(HEIGHT - 1)) : (pos_reg == PW'(WIDTH - 1));
  assign last_line  = col_phase_reg & (line_reg == PW'(WIDTH - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_en) state_next = SCAN;
      SCAN:    if (last_pix) state_next = FINISH;
      FINISH:  state_next = last_line ? DONE : SCAN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state_reg <= IDLE;
    else             state_reg <= state_next;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      word_cnt_reg  <= '0;
      loaded_reg    <= 1'b0;
      grid_ptr_reg  <= '0;
      col_phase_reg <= 1'b0;
      line_reg      <= '0;
      pos_reg       <= '0;
      run_reg       <= '0;
      k_reg         <= '0;
      fail_reg      <= 1'b0;
      row_ok_reg    <= '0;
      col_ok_reg    <= '0;
      solved_reg    <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= (state_reg == DONE);
      if (clear_en) begin
        word_cnt_reg <= '0;
        loaded_reg   <= 1'b0;
        row_ok_reg   <= '0;
        col_ok_reg   <= '0;
        solved_reg   <= 1'b0;
      end else if (load_en) begin
        word_cnt_reg <= word_cnt_reg + LW'(1);
        if (word_cnt_reg == LW'(LINES - 1)) loaded_reg <= 1'b1;
      end
      if (grid_en)
        grid_ptr_reg <= (grid_ptr_reg == RW'(HEIGHT - 1)) ? '0 : (grid_ptr_reg + RW'(1));
      if (start_en) begin
        row_ok_reg    <= '0;
        col_ok_reg    <= '0;
        solved_reg    <= 1'b0;
        col_phase_reg <= 1'b0;
        line_reg      <= '0;
        pos_reg       <= '0;
        run_reg       <= '0;
        k_reg         <= '0;
        fail_reg      <= 1'b0;
      end
      case (state_reg)
        SCAN: begin
          pos_reg <= pos_reg + PW'(1);
          if (pixel) begin
            run_reg <= run_reg + FIELD_W'(1);
          end else if (run_open) begin
            fail_reg <= fail_reg | close_fail;
            k_reg    <= k_inc;
            run_reg  <= '0;
          end
        end
        FINISH: begin
          if (col_phase_reg) col_ok_reg[line_reg]          <= ~line_fail;
          else               row_ok_reg[line_reg[RW-1:0]]  <= ~line_fail;
          pos_reg  <= '0;
          run_reg  <= '0;
          k_reg    <= '0;
          fail_reg <= 1'b0;
          if (!col_phase_reg && line_reg == PW'(HEIGHT - 1)) begin
            col_phase_reg <= 1'b1;
            line_reg      <= '0;
          end else begin
            line_reg <= line_reg + PW'(1);
          end
        end
        DONE:    solved_reg <= (&row_ok_reg) & (&col_ok_reg);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (load_en) cons_mem[word_cnt_reg] <= constraints_in;
    if (grid_en) grid_mem[grid_ptr_reg] <= grid_row_in;
  end

  assign constraints_loaded_out = loaded_reg;
  assign busy_out               = ~idle;
  assign done_out               = done_reg;
  assign row_ok_out             = row_ok_reg;
  assign col_ok_out             = col_ok_reg;
  assign solved_out             = solved_reg;

endmodule

// File: tb/tb_nonogram_solution_checker.sv
// Self-checking bench: a run-list model of every line against directed and random grids.
module tb_nonogram_solution_checker;

  localparam int H  = 30;
  localparam int W  = 40;
  localparam int NW = 70;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cvalid = 1'b0, cclear = 1'b0, gvalid = 1'b0, start = 1'b0;
  logic [119:0] cword = '0;
  logic [39:0]  grow = '0;
  logic         loaded, busy, done, solved;
  logic [29:0]  row_ok;
  logic [39:0]  col_ok;

  always #5 clk = ~clk;

  nonogram_solution_checker dut (
    .clk_in                 (clk),
    .reset_n_in             (reset_n),
    .constraint_valid_in    (cvalid),
    .constraints_in         (cword),
    .constraint_clear_in    (cclear),
    .grid_valid_in          (gvalid),
    .grid_row_in            (grow),
    .check_start_in         (start),
    .constraints_loaded_out (loaded),
    .busy_out               (busy),
    .done_out               (done),
    .row_ok_out             (row_ok),
    .col_ok_out             (col_ok),
    .solved_out             (solved)
  );

  int checks = 0;
  int failures = 0;

  logic [119:0] tb_words [NW];
  logic [39:0]  tb_grid [H];
  logic         exp_loaded = 1'b0, exp_solved = 1'b0;
  logic [29:0]  exp_row = '0;
  logic [39:0]  exp_col = '0;
  logic [29:0]  m_row;
  logic [39:0]  m_col;
  logic         m_solved;
  bit           cmp_en = 1'b0, in_check = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Outputs between checks must hold the model's last results.
  always @(negedge clk) begin
    if (cmp_en && !in_check) begin
      chk("loaded", 64'(loaded), 64'(exp_loaded));
      chk("busy_idle", 64'(busy), 64'(0));
      chk("done_idle", 64'(done), 64'(0));
      chk("row_ok", 64'(row_ok), 64'(exp_row));
      chk("col_ok", 64'(col_ok), 64'(exp_col));
      chk("solved", 64'(solved), 64'(exp_solved));
    end
  end

  function automatic bit line_ok(input logic [39:0] bits, input int len, input logic [119:0] word);
    int runs[$];
    int flds[$];
    int r = 0;
    for (int i = 0; i < len; i++) begin
      if (bits[i]) r++;
      else if (r > 0) begin runs.push_back(r); r = 0; end
    end
    if (r > 0) runs.push_back(r);
    for (int k = 0; k < 20; k++) begin
      int f;
      f = int'(word[6*k +: 6]);
      if (f == 0) break;
      flds.push_back(f);
    end
    if (runs.size() != flds.size()) return 1'b0;
    foreach (runs[i]) if (runs[i] != flds[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [39:0] col_bits(input int j);
    logic [39:0] b = '0;
    for (int i = 0; i < H; i++) b[i] = tb_grid[i][j];
    return b;
  endfunction

  function automatic logic [119:0] word_of(input logic [39:0] bits, input int len);
    logic [119:0] w = '0;
    int k = 0;
    int r = 0;
    for (int i = 0; i <= len; i++) begin
      if (i < len && bits[i]) r++;
      else if (r > 0) begin
        if (k < 20) begin w[6*k +: 6] = 6'(r); k++; end
        r = 0;
      end
    end
    return w;
  endfunction

  task automatic model_update();
    for (int i = 0; i < H; i++) m_row[i] = line_ok(tb_grid[i], W, tb_words[i]);
    for (int j = 0; j < W; j++) m_col[j] = line_ok(col_bits(j), H, tb_words[H + j]);
    m_solved = (&m_row) & (&m_col);
  endtask

  task automatic set_uniform();
    for (int i = 0; i < H; i++) tb_words[i] = 120'h28;
    for (int j = 0; j < W; j++) tb_words[H + j] = 120'h1E;
    for (int i = 0; i < H; i++) tb_grid[i] = '1;
  endtask

  task automatic load_constraints();
    cclear = 1'b1;
    @(posedge clk); #1;
    cclear = 1'b0;
    exp_loaded = 1'b0; exp_row = '0; exp_col = '0; exp_solved = 1'b0;
    for (int w = 0; w < NW; w++) begin
      cvalid = 1'b1; cword = tb_words[w];
      @(posedge clk); #1;
    end
    cvalid = 1'b0;
    exp_loaded = 1'b1;
  endtask

  task automatic load_grid();
    for (int i = 0; i < H; i++) begin
      gvalid = 1'b1; grow = tb_grid[i];
      @(posedge clk); #1;
    end
    gvalid = 1'b0;
  endtask

  task automatic run_check(input string tag, input bit inject);
    int n = 0;
    model_update();
    in_check = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (inject && n == 100) begin
        start = 1'b1; cvalid = 1'b1; gvalid = 1'b1; cclear = 1'b1;
        cword = 120'({$urandom(), $urandom(), $urandom(), $urandom()});
        grow  = 40'({$urandom(), $urandom()});
      end else if (inject && n == 101) begin
        start = 1'b0; cvalid = 1'b0; gvalid = 1'b0; cclear = 1'b0;
      end
    end
    chk("done_latency", 64'(n), 64'(2471));
    chk("row_ok_at_done", 64'(row_ok), 64'(m_row));
    chk("col_ok_at_done", 64'(col_ok), 64'(m_col));
    chk("solved_at_done", 64'(solved), 64'(m_solved));
    @(posedge clk); #1;
    chk("done_pulse_width", 64'(done), 64'(0));
    exp_row = m_row; exp_col = m_col; exp_solved = m_solved;
    in_check = 1'b0;
    $display("check %s: cycles=%0d row_ok=%h col_ok=%h solved=%0d", tag, n, row_ok, col_ok, solved);
  endtask

  task automatic try_start_ignored(input string tag);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ignored_start_busy", 64'(busy), 64'(0));
    repeat (5) @(posedge clk);
    #1;
    $display("start %s: ignored, busy=%0d", tag, busy);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [119:0] w;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cmp_en = 1'b1;

    // All-ones grid against single full-length runs.
    set_uniform();
    load_grid();
    load_constraints();
    run_check("uniform", 1'b0);
    chk("lit_uniform_row", 64'(row_ok), 64'(30'h3FFF_FFFF));
    chk("lit_uniform_col", 64'(col_ok), 64'(40'hFF_FFFF_FFFF));
    chk("lit_uniform_solved", 64'(solved), 64'(1));

    // Reset with results set, then reset again in the middle of a load.
    reset_n = 1'b0;
    exp_loaded = 1'b0; exp_row = '0; exp_col = '0; exp_solved = 1'b0;
    #1;
    chk("reset_loaded", 64'(loaded), 64'(0));
    chk("reset_row_ok", 64'(row_ok), 64'(0));
    chk("reset_solved", 64'(solved), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int w2 = 0; w2 < 35; w2++) begin
      cvalid = 1'b1; cword = tb_words[w2];
      @(posedge clk); #1;
    end
    cvalid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    load_grid();
    for (int w2 = 0; w2 < NW - 1; w2++) begin
      cvalid = 1'b1; cword = tb_words[w2];
      @(posedge clk); #1;
    end
    chk("loaded_after_69", 64'(loaded), 64'(0));
    cword = tb_words[NW - 1];
    @(posedge clk); #1;
    cvalid = 1'b0;
    exp_loaded = 1'b1;
    run_check("after_reset", 1'b0);

    // One missing pixel breaks exactly its row and column.
    tb_grid[0][5] = 1'b0;
    load_grid();
    run_check("hole_0_5", 1'b0);
    chk("lit_hole_row", 64'(row_ok), 64'(30'h3FFF_FFFE));
    chk("lit_hole_col", 64'(col_ok), 64'(40'hFF_FFFF_FFDF));
    chk("lit_hole_solved", 64'(solved), 64'(0));

    // Row 0 expects runs {3,1}.
    tb_words[0] = 120'h43;
    load_constraints();
    tb_grid[0] = 40'h17;
    load_grid();
    run_check("row0_3_1", 1'b0);
    chk("lit_31_pass", 64'(row_ok[0]), 64'(1));
    tb_grid[0] = 40'h1D;
    load_grid();
    run_check("row0_1_3", 1'b0);
    chk("lit_13_fail", 64'(row_ok[0]), 64'(0));
    tb_grid[0] = 40'h80_0000_0017;
    load_grid();
    run_check("row0_extra", 1'b0);
    chk("lit_extra_fail", 64'(row_ok[0]), 64'(0));

    // Twenty single-pixel runs: 20 fields pass, 19 fields fail.
    w = '0;
    for (int k = 0; k < 20; k++) w[6*k +: 6] = 6'd1;
    tb_words[0] = w;
    tb_grid[0] = 40'h55_5555_5555;
    load_constraints();
    load_grid();
    run_check("alt20", 1'b0);
    chk("lit_alt20_pass", 64'(row_ok[0]), 64'(1));
    w[6*19 +: 6] = 6'd0;
    tb_words[0] = w;
    load_constraints();
    run_check("alt19", 1'b0);
    chk("lit_alt19_fail", 64'(row_ok[0]), 64'(0));

    // Start requests without a full constraint set.
    cclear = 1'b1;
    @(posedge clk); #1;
    cclear = 1'b0;
    exp_loaded = 1'b0; exp_row = '0; exp_col = '0; exp_solved = 1'b0;
    try_start_ignored("after_clear");
    for (int w2 = 0; w2 < 10; w2++) begin
      cvalid = 1'b1; cword = tb_words[w2];
      @(posedge clk); #1;
    end
    cvalid = 1'b0;
    try_start_ignored("partial_load");

    // Inputs raised while busy must not disturb the check or the grid pointer.
    set_uniform();
    tb_grid[7] = 40'h0F_0F0F_0F0F;
    for (int i = 0; i < H; i++) tb_words[i] = word_of(tb_grid[i], W);
    load_constraints();
    load_grid();
    run_check("busy_inject", 1'b1);
    tb_grid[3] = 40'hF0_0000_000F;
    load_grid();
    run_check("after_inject", 1'b0);

    // Random grids with constraints derived from them, then a few flipped pixels.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < H; i++) begin
        logic [39:0] a, b;
        a = 40'({$urandom(), $urandom()});
        b = 40'({$urandom(), $urandom()});
        tb_grid[i] = (t[0]) ? (a | b) : (a & b);
      end
      for (int i = 0; i < H; i++) tb_words[i] = word_of(tb_grid[i], W);
      for (int j = 0; j < W; j++) tb_words[H + j] = word_of(col_bits(j), H);
      for (int f = 0; f < int'($urandom_range(0, 3)); f++) begin
        int r, c;
        r = int'($urandom_range(0, H - 1));
        c = int'($urandom_range(0, W - 1));
        tb_grid[r][c] = ~tb_grid[r][c];
      end
      load_constraints();
      load_grid();
      run_check($sformatf("random_%0d", t), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
